// File: rtl/byte_fifo_pkg.sv
// Shared constants for the byte FIFO and the downstream 8-to-5 symbol modulator chain.
package byte_fifo_pkg;

  localparam int unsigned ByteWidth    = 8;
  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned SymbolWidth  = 5;

endpackage

// File: rtl/byte_fifo_mem.sv
// Byte register array: clocked write port, asynchronous read port for first-word-fall-through.
module byte_fifo_mem
  import byte_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [ByteWidth-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [ByteWidth-1:0] rdata
);

  logic [ByteWidth-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with sticky overflow/underflow flags.
// Optional occupancy output enabled by defining BYTE_FIFO_LEVEL_EN.
module byte_fifo
  import byte_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ByteWidth-1:0] din,
  input  logic                 rd,
  output logic [ByteWidth-1:0] dout,
  output logic                 rdy,
  output logic                 full,
  output logic                 ovf,
  output logic                 udf
`ifdef BYTE_FIFO_LEVEL_EN
  ,
  output logic [AW:0]          level
`endif
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        rd_acc, wr_acc;

  assign rdy  = (wptr_q == rptr_q);
  assign full = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
  assign rd_acc = rd & ~rdy;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    if (wr_en && !wr_acc) ovf_d = 1'b1;
    if (rd && rdy) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;

`ifdef BYTE_FIFO_LEVEL_EN
  logic [AW:0] level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= wptr_d - rptr_d;
    end
  end

  assign level = level_q;
`endif

  byte_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (din),
    .raddr (rptr_q[AW-1:0]),
    .rdata (dout)
  );

endmodule

// File: tb/tb_byte_fifo.sv
// Scoreboard bench for byte_fifo: directed stimulus, expected bytes queued, monitor compares reads.
module tb_byte_fifo;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] din;
  logic       rd;
  logic [7:0] dout;
  logic       rdy, full, ovf, udf;
`ifdef BYTE_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];
  logic [4:0] sym_q [$];
  int         model_cnt = 0;
  bit         mod_on = 1'b0;
  logic [15:0] bitbuf = '0;
  int          nbits = 0;

  always #5 clk = ~clk;

  byte_fifo #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .din   (din),
    .rd    (rd),
    .dout  (dout),
    .rdy   (rdy),
    .full  (full),
    .ovf   (ovf),
    .udf   (udf)
`ifdef BYTE_FIFO_LEVEL_EN
    ,
    .level (level)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read pops the scoreboard; optional 8-to-5 packer downstream.
  always @(negedge clk) begin
    if (!reset && rd && !rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL read_unexpected: got 0x%0h, expected no data", dout);
      end else begin
        check("read_data", dout, exp_q.pop_front());
      end
      if (mod_on) begin
        bitbuf = (bitbuf << 8) | {8'h00, dout};
        nbits += 8;
        while (nbits >= 5) begin
          logic [4:0] sym;
          sym = 5'((bitbuf >> (nbits - 5)) & 16'h1f);
          nbits -= 5;
          if (sym_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL symbol_extra: got 0x%0h, expected none", sym);
          end else begin
            check("symbol", sym, sym_q.pop_front());
          end
        end
      end
    end
  end

  // One clock of stimulus; the bench's own occupancy model decides what gets queued.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r);
    bit racc, wacc;
    wr_en = w;
    din   = d;
    rd    = r;
    racc  = r && (model_cnt > 0);
    wacc  = w && ((model_cnt < Depth) || racc);
    if (wacc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    model_cnt += int'(wacc) - int'(racc);
    wr_en = 1'b0;
    rd    = 1'b0;
`ifdef BYTE_FIFO_LEVEL_EN
    check("level", level, model_cnt);
`endif
  endtask

  task automatic do_reset(input bit w, input bit r);
    reset = 1'b1;
    wr_en = w;
    din   = 8'h77;
    rd    = r;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    rd    = 1'b0;
    exp_q.delete();
    model_cnt = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * Depth && model_cnt > 0; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drained_rdy", rdy, 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rdy"}, rdy, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_udf"}, udf, 0);
`ifdef BYTE_FIFO_LEVEL_EN
    check({tag, "_level"}, level, 0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    din   = 8'h00;
    rd    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);
    check_reset_state("reset");

    // Single byte round trip.
    cycle(1'b1, 8'hA5, 1'b0);
    check("fwft_rdy", rdy, 0);
    check("fwft_dout", dout, 8'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    check("after_read_rdy", rdy, 1);

    // Fill, overflow, read back in order.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    check("fill_full", full, 1);
    check("fill_no_ovf", ovf, 0);
    cycle(1'b1, 8'hFF, 1'b0);
    check("ovf_set", ovf, 1);
    check("ovf_full", full, 1);
    drain();
    check("ovf_sticky", ovf, 1);
    check("drain_full", full, 0);
    do_reset(1'b0, 1'b0);
    check_reset_state("reset2");

    // Streaming while full across pointer wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    check("stream_fill_full", full, 1);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'h80 + 8'(i), 1'b1);
      check("stream_full", full, 1);
    end
    check("stream_no_ovf", ovf, 0);
    drain();

    // Underflow, and write+read while empty.
    cycle(1'b0, 8'h00, 1'b1);
    check("udf_set", udf, 1);
    check("udf_rdy", rdy, 1);
    cycle(1'b1, 8'h3C, 1'b1);
    check("empty_wr_rd_rdy", rdy, 0);
    check("empty_wr_rd_dout", dout, 8'h3C);
    drain();
    check("udf_sticky", udf, 1);
    do_reset(1'b0, 1'b0);
    check_reset_state("reset3");

    // Modulator chain: 40 bits packed MSB-first into eight 5-bit symbols.
    sym_q = '{5'h1F, 5'h1C, 5'h00, 5'h0A, 5'h14, 5'h15, 5'h0C, 5'h01};
    mod_on = 1'b1;
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b1, 8'h81, 1'b0);
    drain();
    mod_on = 1'b0;
    check("symbols_remaining", sym_q.size(), 0);
    check("symbol_leftover_bits", nbits, 0);

    // Mid-stream reset discards data and overrides a simultaneous write.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
    check("pre_reset_rdy", rdy, 0);
    do_reset(1'b1, 1'b1);
    check_reset_state("midreset");
    cycle(1'b1, 8'h99, 1'b0);
    check("post_reset_dout", dout, 8'h99);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/byte_fifo.md
BYTE_FIFO -- requirements
Module: byte_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning byte entries stored; SHALL be a power of two, 4..256.
REQ-002 Parameter AW, default 4, meaning pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 wr_en  input  1  write request from the byte source.
REQ-006 din  input  8  write data, sampled when wr_en=1.
REQ-007 rd  input  1  read strobe from the downstream symbol modulator.
REQ-008 dout  output  8  head-of-queue byte, first-word-fall-through.
REQ-009 rdy  output  1  empty flag: 1 = no byte available, 0 = dout valid.
REQ-010 full  output  1  1 = DEPTH bytes stored.
REQ-011 ovf  output  1  sticky overflow flag.
REQ-012 udf  output  1  sticky underflow flag.

Function
REQ-013 Storage SHALL be a DEPTH x 8 register array with AW+1-bit write and read pointers; the MSB distinguishes full from empty.
REQ-014 Accepted write: wr_en=1 and (full=0 or accepted read in same cycle); din SHALL be stored at wptr and wptr SHALL advance by 1.
REQ-015 Accepted read: rd=1 and rdy=0; rptr SHALL advance by 1.
REQ-016 dout SHALL always equal mem[rptr] combinationally, so the consumer latches dout in the same cycle it asserts rd.
REQ-017 Write-to-visible latency SHALL be 1 cycle: a byte written into an empty FIFO at edge N SHALL appear on dout with rdy=0 after edge N.
REQ-018 rdy SHALL be 1 exactly when wptr == rptr; full SHALL be 1 exactly when the low AW bits match and the MSBs differ.
REQ-019 Pointers SHALL wrap modulo 2*DEPTH; order and data SHALL be preserved across wrap with no bubbles.
REQ-020 Write while full without a simultaneous accepted read SHALL be dropped, leave memory and pointers unchanged, and set ovf.
REQ-021 Write and accepted read together while full SHALL both be accepted; full SHALL stay 1.
REQ-022 Read while rdy=1 SHALL be ignored, leave pointers unchanged, and set udf.
REQ-023 Write and read in the same cycle while empty SHALL accept the write only; the read SHALL count as underflow.
REQ-024 Write and read together when neither empty nor full SHALL keep occupancy unchanged.
REQ-025 ovf and udf SHALL remain set until reset.

Reset
REQ-026 reset=1 SHALL clear wptr, rptr, ovf and udf at the next rising edge.
REQ-027 After reset: rdy=1, full=0, ovf=0, udf=0; dout value is don't-care, and memory contents are not cleared.
REQ-028 Reset SHALL override a simultaneous wr_en or rd, and all stored bytes are discarded. A mid-stream reset SHALL leave the FIFO empty on the following cycle.

Configuration
REQ-029 Macro BYTE_FIFO_LEVEL_EN: when defined, output level [AW:0] SHALL equal wptr - rptr (0..DEPTH), registered with the pointers, and reset to 0.
REQ-030 Without BYTE_FIFO_LEVEL_EN, the level port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-031 A shared package SHALL hold the byte width constant (8), the default DEPTH, and the symbol width constant (5) used by the modulator chain.
REQ-032 One sub-module, byte_fifo_mem, SHALL hold the register array: write port clocked, read port asynchronous.
REQ-033 Pointer, flag and sticky-error logic SHALL stay in byte_fifo.

Verification
REQ-034 Reset, then write 0xA5 once -> the next cycle gives rdy=0, dout=0xA5; rd=1 for one cycle -> rdy=1.
REQ-035 Write 16 bytes 0x00..0x0F with no reads -> full=1 after the 16th write; a 17th write of 0xFF -> ovf=1 and the read-back sequence is 0x00..0x0F.
REQ-036 Fill to full, then wr_en=1 and rd=1 together for 40 cycles with an incrementing pattern -> full stays 1, no ovf, output order is intact across pointer wrap.
REQ-037 Empty FIFO, rd=1 -> udf=1 and rdy stays 1; same-cycle write 0x3C with rd -> 0x3C is retained and rdy=0 the next cycle.
REQ-038 Connect to the 8-to-5 modulator and push 5 bytes 0xFF,0x00,0xAA,0x55,0x81 -> the FIFO drains to rdy=1 and the downstream emits 8 symbols that match the bit-packed reference.
REQ-039 Write 5 bytes, then assert reset for 1 cycle -> rdy=1, full=0, level=0 (when BYTE_FIFO_LEVEL_EN is defined), and the old data is not readable.
